// File: rtl/pc_gen_unit.sv
// Program-counter generator: holds the fetch PC and picks the next one from the
// sequential increment, a redirect, a return-address-stack pop, or the trap vector.
// Latency: redirect/pop seen in cycle N appears on pc in cycle N+1; a misaligned redirect adds one TRAP bubble.
// Backpressure: pc is held while pc_valid & !fetch_ready, unless a redirect arrives.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   fetch_ready                 fetch accepts the current pc (acc = pc_valid & fetch_ready)
//   redirect_valid/_target      branch/jump taken and its destination
//   call_push, ret_pop          call/return at the accepted pc (ignored unless accepted)
//   pc, pc_valid, pc_plus_inc   current PC, offer qualifier, pc + INC
//   ras_empty, ras_full         return-address-stack occupancy flags
//   fault, ras_underflow        one-cycle event pulses
module pc_gen_unit #(
    parameter int               WIDTH        = 32,
    parameter int               ALIGN_BITS   = 2,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int               DEPTH        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_ready,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             call_push,
    input  logic             ret_pop,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             fault,
    output logic             ras_underflow
);

    localparam int               PW  = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] INC = {{(WIDTH-1){1'b0}}, 1'b1} << ALIGN_BITS;

    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc_nxt;

    // Circular stack: sp is the next write slot, sp-1 the top. Because sp
    // wraps modulo DEPTH, a push into a full stack lands on the oldest entry.
    logic [WIDTH-1:0] ras_mem [DEPTH];
    logic [PW-1:0]    sp, sp_nxt, top_idx, wr_idx;
    logic [PW:0]      cnt, cnt_nxt;
    logic             wr_en;
    logic             underflow_nxt;

    logic             acc, misaligned, do_push, do_pop;
    logic [WIDTH-1:0] ras_top;

    assign pc_plus_inc = pc + INC;
    assign ras_empty   = (cnt == '0);
    assign ras_full    = (cnt == (PW+1)'(DEPTH));
    assign top_idx     = sp - 1'b1;
    assign ras_top     = ras_mem[top_idx];

    assign acc        = pc_valid & fetch_ready;
    assign misaligned = redirect_valid & (redirect_target[ALIGN_BITS-1:0] != '0);
    // A misaligned redirect wipes the stack, so no push/pop is applied with it.
    assign do_push    = acc & call_push & ~misaligned;
    assign do_pop     = acc & ret_pop & ~ras_empty & ~misaligned;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        sp_nxt        = sp;
        cnt_nxt       = cnt;
        wr_en         = 1'b0;
        wr_idx        = sp;
        underflow_nxt = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            TRAP: state_nxt = RUN;
            RUN: begin
                if (misaligned) begin
                    state_nxt = TRAP;
                    pc_nxt    = TRAP_VECTOR;
                    cnt_nxt   = '0;
                end else begin
                    if (redirect_valid) pc_nxt = redirect_target;
                    else if (do_pop)    pc_nxt = ras_top;
                    else if (acc)       pc_nxt = pc_plus_inc;

                    if (do_push && do_pop) begin
                        // call+return at once: replace the top in place
                        wr_en  = 1'b1;
                        wr_idx = top_idx;
                    end else if (do_push) begin
                        wr_en   = 1'b1;
                        sp_nxt  = sp + 1'b1;
                        cnt_nxt = ras_full ? cnt : cnt + 1'b1;
                    end else if (do_pop) begin
                        sp_nxt  = top_idx;
                        cnt_nxt = cnt - 1'b1;
                    end
                    underflow_nxt = acc & ret_pop & ras_empty;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc            <= RESET_VECTOR;
            pc_valid      <= 1'b0;
            fault         <= 1'b0;
            ras_underflow <= 1'b0;
            sp            <= '0;
            cnt           <= '0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            pc_valid      <= (state_nxt == RUN);
            fault         <= (state_nxt == TRAP);
            ras_underflow <= underflow_nxt;
            sp            <= sp_nxt;
            cnt           <= cnt_nxt;
        end
    end

    // Entries are only read when cnt > 0, so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) ras_mem[wr_idx] <= pc_plus_inc;
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        call_push;
    logic        ret_pop;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] pc_plus_inc;
    logic        ras_empty;
    logic        ras_full;
    logic        fault;
    logic        ras_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .call_push      (call_push),
        .ret_pop        (ret_pop),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .pc_plus_inc    (pc_plus_inc),
        .ras_empty      (ras_empty),
        .ras_full       (ras_full),
        .fault          (fault),
        .ras_underflow  (ras_underflow)
    );

    // Advance one clock and land 1ns past the edge, where outputs are sampled
    // and the next inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b0;
        redirect_target = '0; call_push = 1'b0; ret_pop = 1'b0;
        tick(); tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want %h", pc, 32'h0); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", pc_valid); end
        checks++; if (fault !== 1'b0 || ras_underflow !== 1'b0) begin errors++; $display("FAIL rst_pulses: got %b%b want 00", fault, ras_underflow); end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL rst_ras: got empty=%b full=%b want 1 0", ras_empty, ras_full); end
        rst_n = 1'b1;
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b want 0", pc_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc !== exp_pc[i] || pc_valid !== 1'b1) begin errors++; $display("FAIL seq_pc%0d: got %h/%b want %h/1", i, pc, pc_valid, exp_pc[i]); end
        end
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 32'hC || pc_valid !== 1'b1) begin errors++; $display("FAIL stall%0d: got %h/%b want 0000000c/1", i, pc, pc_valid); end
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_target = 32'h200;
        tick();
        checks++; if (pc !== 32'h200 || pc_valid !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL redir_aligned: got %h/%b/%b want 00000200/1/0", pc, pc_valid, fault); end
        redirect_target = 32'h202;
        tick();
        checks++; if (pc !== 32'h100 || pc_valid !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL redir_trap: got %h/%b/%b want 00000100/0/1", pc, pc_valid, fault); end
        redirect_valid = 1'b0; fetch_ready = 1'b1;
        tick();
        checks++; if (pc !== 32'h100 || pc_valid !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL trap_exit: got %h/%b/%b want 00000100/1/0", pc, pc_valid, fault); end
        tick();
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL trap_next: got %h want 00000104", pc); end
    endtask

    task automatic test_calls_returns();
        logic [31:0] tgt [3] = '{32'h40, 32'h80, 32'h200};
        logic [31:0] ret [3] = '{32'h84, 32'h44, 32'h14};
        redirect_valid = 1'b1; redirect_target = 32'h10;
        tick();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL call_setup: got %h want 00000010", pc); end
        // each call jumps to the next call site
        for (int i = 0; i < 3; i++) begin
            call_push = 1'b1; redirect_target = tgt[i];
            tick();
            checks++; if (pc !== tgt[i]) begin errors++; $display("FAIL call%0d_pc: got %h want %h", i, pc, tgt[i]); end
        end
        call_push = 1'b0; redirect_valid = 1'b0;
        checks++; if (ras_empty !== 1'b0 || ras_full !== 1'b0) begin errors++; $display("FAIL calls_ras: got empty=%b full=%b want 0 0", ras_empty, ras_full); end
        ret_pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== ret[i] || ras_underflow !== 1'b0) begin errors++; $display("FAIL ret%0d: got %h/uf=%b want %h/0", i, pc, ras_underflow, ret[i]); end
        end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL rets_empty: got %b want 1", ras_empty); end
        tick();
        checks++; if (pc !== 32'h18 || ras_underflow !== 1'b1) begin errors++; $display("FAIL underflow: got %h/uf=%b want 00000018/1", pc, ras_underflow); end
        ret_pop = 1'b0;
        tick();
        checks++; if (pc !== 32'h1C || ras_underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %h/uf=%b want 0000001c/0", pc, ras_underflow); end
    endtask

    task automatic test_overflow();
        // pushes at 0x1C..0x2C store 0x20..0x30; 0x20 is overwritten by 0x30
        logic [31:0] exp_pop [4] = '{32'h30, 32'h2C, 32'h28, 32'h24};
        call_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (ras_full !== (i >= 3)) begin errors++; $display("FAIL push%0d_full: got %b want %b", i, ras_full, (i >= 3)); end
        end
        call_push = 1'b0;
        checks++; if (pc !== 32'h30) begin errors++; $display("FAIL push_pc: got %h want 00000030", pc); end
        ret_pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc !== exp_pop[i]) begin errors++; $display("FAIL ovf_pop%0d: got %h want %h", i, pc, exp_pop[i]); end
        end
        tick();
        checks++; if (pc !== 32'h28 || ras_underflow !== 1'b1) begin errors++; $display("FAIL ovf_lost: got %h/uf=%b want 00000028/1", pc, ras_underflow); end
        ret_pop = 1'b0;
    endtask

    task automatic test_push_pop();
        redirect_valid = 1'b1; redirect_target = 32'h4C;
        tick();
        call_push = 1'b1; redirect_target = 32'h30;
        tick();
        checks++; if (pc !== 32'h30 || ras_empty !== 1'b0) begin errors++; $display("FAIL pp_setup: got %h/empty=%b want 00000030/0", pc, ras_empty); end
        redirect_valid = 1'b0; ret_pop = 1'b1;
        tick();
        checks++; if (pc !== 32'h50 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin errors++; $display("FAIL pp_both: got %h/e=%b/f=%b want 00000050/0/0", pc, ras_empty, ras_full); end
        call_push = 1'b0;
        tick();
        checks++; if (pc !== 32'h34 || ras_empty !== 1'b1) begin errors++; $display("FAIL pp_newtop: got %h/empty=%b want 00000034/1", pc, ras_empty); end
        tick();
        checks++; if (pc !== 32'h38 || ras_underflow !== 1'b1) begin errors++; $display("FAIL pp_count: got %h/uf=%b want 00000038/1", pc, ras_underflow); end
        ret_pop = 1'b0;
    endtask

    task automatic test_trap_clears_ras();
        call_push = 1'b1;
        tick();
        call_push = 1'b0;
        checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL tc_push: got empty=%b want 0", ras_empty); end
        redirect_valid = 1'b1; redirect_target = 32'h401;
        tick();
        redirect_valid = 1'b0;
        checks++; if (ras_empty !== 1'b1 || pc !== 32'h100 || fault !== 1'b1) begin errors++; $display("FAIL tc_clear: got empty=%b pc=%h fault=%b want 1 00000100 1", ras_empty, pc, fault); end
        tick();
    endtask

    task automatic test_wrap();
        fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFFC || pc_plus_inc !== 32'h0) begin errors++; $display("FAIL wrap_pre: got %h/%h want fffffffc/00000000", pc, pc_plus_inc); end
        fetch_ready = 1'b1;
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap: got %h want 00000000", pc); end
    endtask

    task automatic test_reset_mid_stall();
        redirect_valid = 1'b1; redirect_target = 32'h300; call_push = 1'b1;
        tick();
        redirect_valid = 1'b0; call_push = 1'b0; fetch_ready = 1'b0;
        tick();
        checks++; if (pc !== 32'h300 || ras_empty !== 1'b0) begin errors++; $display("FAIL mid_setup: got %h/empty=%b want 00000300/0", pc, ras_empty); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h0 || pc_valid !== 1'b0 || ras_empty !== 1'b1) begin errors++; $display("FAIL async_rst: got %h/v=%b/e=%b want 00000000/0/1", pc, pc_valid, ras_empty); end
        tick();
        rst_n = 1'b1; fetch_ready = 1'b1;
        tick();
        checks++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin errors++; $display("FAIL rerun: got %h/%b want 00000000/1", pc, pc_valid); end
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL rerun_inc: got %h want 00000004", pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_calls_returns();
        test_overflow();
        test_push_pop();
        test_trap_clears_ras();
        test_wrap();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
